// File: rtl/tx_upmix.sv
// tx_upmix: zero-order-hold baseband upconverter with an internal quarter-wave NCO.
// dac = sat(round(I*cos - Q*sin)) with a fixed 6-clock pipeline after each held sample.
module tx_upmix #(
  parameter int IQW     = 18,
  parameter int DACW    = 14,
  parameter int LUTBITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            freq,
  input  logic [7:0]             rate,
  input  logic                   tx_enable,
  input  logic signed [IQW-1:0]  tx_i,
  input  logic signed [IQW-1:0]  tx_q,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic signed [DACW-1:0] dac,
  output logic                   underflow,
  output logic [15:0]            underflow_cnt
);
  localparam int LUTN  = 2 ** LUTBITS;
  localparam int PW    = IQW + 18;
  localparam int DW    = PW + 1;
  localparam int SHIFT = IQW + 18 - 1 - DACW;
  localparam int RW    = DW + 1 - SHIFT;
  localparam logic signed [DW:0]     RND   = {{(DW - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [RW-1:0]   SMAX  = {{(RW - DACW + 1){1'b0}}, {(DACW - 1){1'b1}}};
  localparam logic signed [RW-1:0]   SMIN  = {{(RW - DACW + 1){1'b1}}, {(DACW - 1){1'b0}}};
  localparam logic signed [DACW-1:0] DMAX  = {1'b0, {(DACW - 1){1'b1}}};
  localparam logic signed [DACW-1:0] DMIN  = {1'b1, {(DACW - 1){1'b0}}};
  localparam logic signed [IQW-1:0]  ZIQ   = {IQW{1'b0}};

  function automatic logic [17:0] lut_entry(input int k);
    real ang;
    ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(LUTN);
    return 18'($rtoi(131071.0 * $sin(ang) + 0.5));
  endfunction

  logic [17:0] lut [LUTN];
  for (genvar k = 0; k < LUTN; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  logic signed [IQW-1:0]  mem_i_r [2];
  logic signed [IQW-1:0]  mem_q_r [2];
  logic                   wr_ptr_r, rd_ptr_r;
  logic [1:0]             count_r, count_nx_s;
  logic [7:0]             rate_cnt_r;
  logic [31:0]            phase_r;
  logic signed [IQW-1:0]  hi_r, hq_r;
  logic                   slot_s, push_s, pop_s;

  logic [17:0]            ta_r, tna_r;
  logic [1:0]             quad1_r;
  logic signed [IQW-1:0]  i1_r, q1_r, i2_r, q2_r;
  logic signed [17:0]     sin_s, cos_s, sin2_r, cos2_r;
  logic signed [PW-1:0]   pic3_r, pqs3_r;
  logic signed [DW-1:0]   diff4_r;
  logic signed [DW:0]     sum_s;
  logic signed [RW-1:0]   rnd5_r;

  // Slot/handshake decode and rounding adder
  always_comb begin
    slot_s     = tx_enable && (rate_cnt_r == 8'd0);
    push_s     = tx_valid && tx_ready;
    pop_s      = slot_s && (count_r != 2'd0);
    count_nx_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    sum_s      = $signed({diff4_r[DW-1], diff4_r}) + RND;
  end

  // Sine/cosine quadrant fold of the two ROM words
  always_comb begin
    sin_s = 18'sd0;
    cos_s = 18'sd0;
    case (quad1_r)
      2'd0:    begin sin_s =  $signed(ta_r);  cos_s =  $signed(tna_r); end
      2'd1:    begin sin_s =  $signed(tna_r); cos_s = -$signed(ta_r);  end
      2'd2:    begin sin_s = -$signed(ta_r);  cos_s = -$signed(tna_r); end
      2'd3:    begin sin_s = -$signed(tna_r); cos_s =  $signed(ta_r);  end
      default: begin sin_s =  18'sd0;         cos_s =  18'sd0;         end
    endcase
  end

  // Input buffer, consume-slot timing, NCO phase and held sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_i_r[0]    <= ZIQ;
      mem_i_r[1]    <= ZIQ;
      mem_q_r[0]    <= ZIQ;
      mem_q_r[1]    <= ZIQ;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      tx_ready      <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
      rate_cnt_r    <= 8'd0;
      phase_r       <= 32'd0;
      hi_r          <= ZIQ;
      hq_r          <= ZIQ;
    end else begin
      if (push_s) begin
        mem_i_r[wr_ptr_r] <= tx_i;
        mem_q_r[wr_ptr_r] <= tx_q;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r   <= count_nx_s;
      tx_ready  <= (count_nx_s != 2'd2);
      underflow <= slot_s && (count_r == 2'd0);
      if (slot_s && (count_r == 2'd0) && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
      if (!tx_enable) begin
        phase_r    <= 32'd0;
        rate_cnt_r <= 8'd0;
        hi_r       <= ZIQ;
        hq_r       <= ZIQ;
      end else begin
        phase_r    <= phase_r + freq;
        rate_cnt_r <= slot_s ? rate : (rate_cnt_r - 8'd1);
        if (pop_s) begin
          hi_r <= mem_i_r[rd_ptr_r];
          hq_r <= mem_q_r[rd_ptr_r];
        end else if (slot_s) begin
          hi_r <= ZIQ;
          hq_r <= ZIQ;
        end
      end
    end
  end

  // Six-stage mixing pipeline: ROM, fold, multiply, subtract, round, saturate
  always_ff @(posedge clk) begin
    if (!rst) begin
      ta_r    <= 18'd0;
      tna_r   <= 18'd0;
      quad1_r <= 2'd0;
      i1_r    <= ZIQ;
      q1_r    <= ZIQ;
      sin2_r  <= 18'sd0;
      cos2_r  <= 18'sd0;
      i2_r    <= ZIQ;
      q2_r    <= ZIQ;
      pic3_r  <= {PW{1'b0}};
      pqs3_r  <= {PW{1'b0}};
      diff4_r <= {DW{1'b0}};
      rnd5_r  <= {RW{1'b0}};
      dac     <= {DACW{1'b0}};
    end else begin
      ta_r    <= lut[phase_r[29 -: LUTBITS]];
      tna_r   <= lut[~phase_r[29 -: LUTBITS]];
      quad1_r <= phase_r[31:30];
      i1_r    <= hi_r;
      q1_r    <= hq_r;
      sin2_r  <= sin_s;
      cos2_r  <= cos_s;
      i2_r    <= i1_r;
      q2_r    <= q1_r;
      pic3_r  <= $signed({{18{i2_r[IQW-1]}}, i2_r}) * $signed({{IQW{cos2_r[17]}}, cos2_r});
      pqs3_r  <= $signed({{18{q2_r[IQW-1]}}, q2_r}) * $signed({{IQW{sin2_r[17]}}, sin2_r});
      diff4_r <= $signed({pic3_r[PW-1], pic3_r}) - $signed({pqs3_r[PW-1], pqs3_r});
      rnd5_r  <= sum_s[DW:SHIFT];
      if (rnd5_r > SMAX) begin
        dac <= DMAX;
      end else if (rnd5_r < SMIN) begin
        dac <= DMIN;
      end else begin
        dac <= rnd5_r[DACW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_tx_upmix.sv
// Randomised scoreboard bench for tx_upmix: a sample-level reference model queues the
// expected per-clock outputs, and a monitor compares them against the DUT on the falling edge.
module tb_tx_upmix;
  localparam int IQW = 18, DACW = 14, LUTBITS = 10;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [31:0]            freq;
  logic [7:0]             rate;
  logic                   tx_enable;
  logic signed [IQW-1:0]  tx_i, tx_q;
  logic                   tx_valid;
  logic                   tx_ready;
  logic signed [DACW-1:0] dac;
  logic                   underflow;
  logic [15:0]            underflow_cnt;

  always #5 clk = ~clk;

  tx_upmix #(.IQW(IQW), .DACW(DACW), .LUTBITS(LUTBITS)) dut (
    .clk(clk), .rst(rst), .freq(freq), .rate(rate), .tx_enable(tx_enable),
    .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dac(dac), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  typedef struct {
    int dac;
    int ready;
    int uf;
    int ucnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;

  int          tab[1024];
  int          fifo_i[$], fifo_q[$];
  int          held_i, held_q, rate_cnt_m, ucnt_m, ready_m, uf_m;
  logic [31:0] phase_m;
  int          hist[6];

  // Mixed, rounded and saturated value of one held sample at a given phase
  function automatic int mix(int i, int q, logic [31:0] ph);
    int a, na, s, c;
    longint acc, r;
    a  = int'(ph[29:20]);
    na = 1023 - a;
    case (ph[31:30])
      2'd0:    begin s =  tab[a];  c =  tab[na]; end
      2'd1:    begin s =  tab[na]; c = -tab[a];  end
      2'd2:    begin s = -tab[a];  c = -tab[na]; end
      default: begin s = -tab[na]; c =  tab[a];  end
    endcase
    acc = longint'(i) * longint'(c) - longint'(q) * longint'(s);
    r   = (acc + 64'sd1048576) >>> 21;
    if (r > 64'sd8191) r = 64'sd8191;
    if (r < -64'sd8192) r = -64'sd8192;
    return int'(r);
  endfunction

  // Advance the reference model by one clock using the inputs about to be sampled
  task automatic model_step();
    exp_t e;
    int   slot, push;
    if (!rst) begin
      fifo_i.delete();
      fifo_q.delete();
      held_i = 0; held_q = 0; rate_cnt_m = 0; ucnt_m = 0; ready_m = 0; uf_m = 0;
      phase_m = 32'd0;
      for (int k = 0; k < 6; k++) hist[k] = 0;
      e.dac = 0;
    end else begin
      push = (tx_valid && ready_m != 0) ? 1 : 0;
      slot = (tx_enable && rate_cnt_m == 0) ? 1 : 0;
      uf_m = 0;
      if (!tx_enable) begin
        held_i = 0; held_q = 0; rate_cnt_m = 0; phase_m = 32'd0;
      end else begin
        if (slot != 0) begin
          if (fifo_i.size() > 0) begin
            held_i = fifo_i.pop_front();
            held_q = fifo_q.pop_front();
          end else begin
            held_i = 0; held_q = 0; uf_m = 1;
            if (ucnt_m < 65535) ucnt_m++;
          end
          rate_cnt_m = int'(rate);
        end else begin
          rate_cnt_m--;
        end
        phase_m = phase_m + freq;
      end
      if (push != 0) begin
        fifo_i.push_back(int'(tx_i));
        fifo_q.push_back(int'(tx_q));
      end
      ready_m = (fifo_i.size() < 2) ? 1 : 0;
      e.dac = hist[5];
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = mix(held_i, held_q, phase_m);
    end
    e.ready = ready_m;
    e.uf    = uf_m;
    e.ucnt  = ucnt_m;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected record per clock, compared away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dac", int'(dac), e.dac);
        chk("tx_ready", int'(tx_ready), e.ready);
        chk("underflow", int'(underflow), e.uf);
        chk("underflow_cnt", int'(underflow_cnt), e.ucnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    for (int k = 0; k < 1024; k++)
      tab[k] = $rtoi(131071.0 * $sin(real'(2 * k + 1) * 3.14159265358979 / 4096.0) + 0.5);

    // Reset held with a valid source present
    rst = 1'b0; freq = 32'd0; rate = 8'd0; tx_enable = 1'b0;
    tx_i = 18'sd0; tx_q = 18'sd0; tx_valid = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();

    // Full-scale I at zero phase saturates positive
    tx_i = 18'sd131071; tx_q = 18'sd0;
    repeat (3) tick();
    tx_enable = 1'b1;
    repeat (20) tick();

    // Quarter-rate NCO
    freq = 32'h4000_0000; tx_i = 18'sd65536;
    repeat (16) tick();

    // Single preloaded sample then underflow at the next slot
    rst = 1'b0; tick();
    rst = 1'b1; tx_enable = 1'b0; freq = 32'd0; rate = 8'd3; tick();
    tx_valid = 1'b1; tx_i = 18'sd65536; tx_q = 18'sd0; tick();
    tx_valid = 1'b0; tx_enable = 1'b1;
    repeat (16) tick();

    // Back-pressure with a changing I pattern at rate 3
    tx_valid = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tx_i = 18'(((k * 7919) % 262144) - 131072);
      tx_q = 18'(int'($urandom_range(0, 2000)) - 1000);
      tick();
    end

    // Negative saturation, disable drain, phase restart on re-enable
    rate = 8'd0; freq = 32'd0; tx_i = -18'sd131072; tx_q = 18'sd131071;
    repeat (15) tick();
    tx_enable = 1'b0;
    repeat (10) tick();
    tx_enable = 1'b1; freq = 32'h4000_0000; tx_i = 18'sd65536; tx_q = 18'sd0;
    repeat (10) tick();

    // Random traffic with occasional mid-run reset
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tx_enable = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
      tx_valid  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      tx_i      = 18'($urandom);
      tx_q      = 18'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        rate = 8'($urandom_range(0, 5));
        freq = $urandom;
      end
      tick();
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
